// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg
// Shared definitions for the program-mode loader and its neighbours.
// Holds the state encoding used by the loader FSM and the default
// address/data widths. The RAM and address-mux wrappers use the same
// widths so that all three agree on a single source.
// No ports (package).
package ram_loader_pkg;

    // Default geometry shared with the RAM and mux wrappers.
    localparam int DEFAULT_ADDR_W       = 4;
    localparam int DEFAULT_DATA_W       = 8;
    localparam int DEFAULT_WRITE_CYCLES = 2;

    // State encoding of the loader sequencer.
    localparam int          STATE_W  = 3;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_WAIT  = 3'd1;
    localparam logic [2:0]  ST_SETUP = 3'd2;
    localparam logic [2:0]  ST_WRITE = 3'd3;
    localparam logic [2:0]  ST_HOLD  = 3'd4;
    localparam logic [2:0]  ST_DONE  = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_WAIT  = ST_WAIT,
        S_SETUP = ST_SETUP,
        S_WRITE = ST_WRITE,
        S_HOLD  = ST_HOLD,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/ram_loader_write_timer.sv
// loader_write_timer
// Measures the length of the WRITE phase of a loader frame.
// A one-cycle 'start' pulse, given in the cycle before WRITE begins,
// loads the counter; 'expired' is high during the last WRITE cycle,
// telling the FSM to move on to HOLD at the following edge.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   load the counter for a new WRITE phase
//   expired  out  current cycle is the last WRITE cycle
module loader_write_timer
    import ram_loader_pkg::*;
#(
    parameter int WRITE_CYCLES = DEFAULT_WRITE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic expired
);

    localparam int CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WRITE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter holds the number of WRITE cycles still to follow the
    // current one, so it reads zero in the final WRITE cycle and rests
    // at zero while no frame is running.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/ram_loader.sv
// ram_loader
// Program-mode sequencer in front of the RAM address multiplexer.
// While prog_en is high it takes bytes over a valid/ready handshake and
// writes each one to an auto-incrementing address using a
// SETUP / WRITE / HOLD framed strobe. Outside program mode it releases
// the mux so the memory address register drives RAM again.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   prog_en     in   level, requests program mode
//   data_in     in   byte to store
//   data_valid  in   data_in is valid
//   data_ready  out  a byte can be accepted this cycle
//   prog_addr   out  address for the mux program input
//   mux_sel     out  mux select, 1 = program address
//   wr_data     out  registered byte presented to RAM
//   wr_en       out  RAM write strobe
//   busy        out  a write frame is in progress
//   done        out  every location has been written
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int WRITE_CYCLES = DEFAULT_WRITE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              mux_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              abort_q,   abort_d;
    logic              timer_start;
    logic              timer_expired;

    loader_write_timer #(
        .WRITE_CYCLES(WRITE_CYCLES)
    ) u_write_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (timer_start),
        .expired (timer_expired)
    );

    // The timer is armed during SETUP so that its count is valid from
    // the first WRITE cycle onward.
    assign timer_start = (state_q == S_SETUP);

    // Next-state logic. abort_q remembers that prog_en went low while
    // the strobe was already committed, so the frame still finishes but
    // ends in IDLE even if prog_en comes back before HOLD.
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        wr_data_d   = wr_data_q;
        abort_d     = abort_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (prog_en) begin
                    state_d     = S_WAIT;
                    prog_addr_d = '0;
                end
            end
            S_WAIT: begin
                if (!prog_en) begin
                    state_d = S_IDLE;
                end else if (data_valid) begin
                    wr_data_d = data_in;
                    abort_d   = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!prog_en) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!prog_en) begin
                    abort_d = 1'b1;
                end
                if (timer_expired) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                abort_d = 1'b0;
                if (prog_addr_q != ADDR_LAST) begin
                    prog_addr_d = prog_addr_q + ADDR_W'(1);
                end
                if (abort_q || !prog_en) begin
                    state_d = S_IDLE;
                end else if (prog_addr_q == ADDR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (!prog_en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, address, data and abort registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prog_addr_q <= '0;
            wr_data_q   <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            wr_data_q   <= wr_data_d;
            abort_q     <= abort_d;
        end
    end

    // Handshake and strobe outputs are decoded from the state register
    // alone, so a reset drops them without waiting for a clock edge.
    always_comb begin
        data_ready = (state_q == S_WAIT);
        mux_sel    = (state_q != S_IDLE);
        wr_en      = (state_q == S_WRITE);
        busy       = (state_q == S_SETUP) || (state_q == S_WRITE) ||
                     (state_q == S_HOLD);
        done       = (state_q == S_DONE);
    end

    assign prog_addr = prog_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader
// Self-checking bench for ram_loader with its default geometry
// (16 locations, 8-bit data, 2 write cycles). A frame-level model
// predicts every output each cycle; directed sequences add literal
// expectations for reset, single write, aborts, full fill and an
// asynchronous reset during WRITE.
module tb_ram_loader;

    localparam int A     = 4;
    localparam int D     = 8;
    localparam int WC    = 2;
    localparam int DEPTH = 1 << A;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_FRAME = 2;
    localparam int M_DONE  = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         prog_en = 1'b0;
    logic [D-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic [A-1:0] prog_addr;
    logic         mux_sel;
    logic [D-1:0] wr_data;
    logic         wr_en;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    bit checking_en = 1'b0;

    // Frame-level model: mode, position inside a frame (0 = setup,
    // 1..WC = strobe cycles, WC+1 = hold), address and latched byte.
    int m_mode  = M_IDLE;
    int m_k     = 0;
    int m_addr  = 0;
    int m_data  = 0;
    bit m_abort = 1'b0;

    // RAM image and strobe counter built from what the DUT writes.
    logic [D-1:0] mem [DEPTH];
    int  write_count = 0;
    bit  wr_prev = 1'b0;

    ram_loader #(
        .ADDR_W       (A),
        .DATA_W       (D),
        .WRITE_CYCLES (WC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_en    (prog_en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .prog_addr  (prog_addr),
        .mux_sel    (mux_sel),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Counts one comparison and reports it when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drives one cycle's worth of inputs on the falling edge.
    task automatic applyStimulus(input logic pe, input logic dv,
                                 input logic [D-1:0] d);
        @(negedge clk);
        prog_en    = pe;
        data_valid = dv;
        data_in    = d;
    endtask

    // Model update at each rising edge, following the loader's rules:
    // handshake in wait, a fixed frame of setup/strobe/hold, address
    // advance after hold, aborts ending the session in idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_k     <= 0;
            m_addr  <= 0;
            m_data  <= 0;
            m_abort <= 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (prog_en) begin
                        m_mode <= M_WAIT;
                        m_addr <= 0;
                    end
                end
                M_WAIT: begin
                    if (!prog_en) begin
                        m_mode <= M_IDLE;
                    end else if (data_valid) begin
                        m_mode  <= M_FRAME;
                        m_k     <= 0;
                        m_data  <= int'(data_in);
                        m_abort <= 1'b0;
                    end
                end
                M_FRAME: begin
                    if (m_k == 0) begin
                        if (!prog_en) m_mode <= M_IDLE;
                        else          m_k <= 1;
                    end else if (m_k <= WC) begin
                        if (!prog_en) m_abort <= 1'b1;
                        m_k <= m_k + 1;
                    end else begin
                        if (m_addr != DEPTH - 1) m_addr <= m_addr + 1;
                        if (m_abort || !prog_en)      m_mode <= M_IDLE;
                        else if (m_addr == DEPTH - 1) m_mode <= M_DONE;
                        else                          m_mode <= M_WAIT;
                    end
                end
                default: begin
                    if (!prog_en) m_mode <= M_IDLE;
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n && checking_en) begin
            checkOutput("model_data_ready", 32'(data_ready), 32'(m_mode == M_WAIT));
            checkOutput("model_mux_sel", 32'(mux_sel), 32'(m_mode != M_IDLE));
            checkOutput("model_wr_en", 32'(wr_en),
                        32'(m_mode == M_FRAME && m_k >= 1 && m_k <= WC));
            checkOutput("model_busy", 32'(busy), 32'(m_mode == M_FRAME));
            checkOutput("model_done", 32'(done), 32'(m_mode == M_DONE));
            checkOutput("model_prog_addr", 32'(prog_addr), 32'(m_addr));
            checkOutput("model_wr_data", 32'(wr_data), 32'(m_data));
        end
    end

    // RAM image: capture one write per rising strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_prev <= 1'b0;
        end else begin
            wr_prev <= wr_en;
            if (wr_en && !wr_prev) begin
                write_count  <= write_count + 1;
                mem[prog_addr] <= wr_data;
            end
        end
    end

    // Directed sequences with hand-computed expectations.
    initial begin
        logic [5:1] exp_wr;
        logic [5:1] exp_busy;
        logic [5:1] exp_rdy;
        int wc0;
        int b;
        int cycles;

        exp_wr   = 5'b00110;
        exp_busy = 5'b01111;
        exp_rdy  = 5'b10000;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_data_ready", 32'(data_ready), 0);
        checkOutput("reset_prog_addr", 32'(prog_addr), 0);
        checkOutput("reset_mux_sel", 32'(mux_sel), 0);
        checkOutput("reset_wr_data", 32'(wr_data), 0);
        checkOutput("reset_wr_en", 32'(wr_en), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        rst_n = 1'b1;
        checking_en = 1'b1;

        // Idle with data_valid toggling: nothing happens.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'(i % 2), 8'h55);
            checkOutput("idle_wr_en", 32'(wr_en), 0);
            checkOutput("idle_mux_sel", 32'(mux_sel), 0);
        end

        // Single byte 0xA5 at address 0.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hA5);
        checkOutput("enter_wait_ready", 32'(data_ready), 1);
        checkOutput("enter_wait_mux_sel", 32'(mux_sel), 1);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkOutput("single_wr_en", 32'(wr_en), 32'(exp_wr[c]));
            checkOutput("single_busy", 32'(busy), 32'(exp_busy[c]));
            checkOutput("single_ready", 32'(data_ready), 32'(exp_rdy[c]));
            if (c == 2) begin
                checkOutput("single_addr", 32'(prog_addr), 0);
                checkOutput("single_data", 32'(wr_data), 32'h A5);
            end
        end
        checkOutput("single_next_addr", 32'(prog_addr), 1);

        // Abort during SETUP: no strobe, back to idle, restart at 0.
        wc0 = write_count;
        applyStimulus(1'b1, 1'b1, 8'h3C);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_setup_busy", 32'(busy), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_setup_mux_sel", 32'(mux_sel), 0);
        checkOutput("abort_setup_wr_en", 32'(wr_en), 0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("restart_addr", 32'(prog_addr), 0);
        checkOutput("restart_ready", 32'(data_ready), 1);
        checkOutput("abort_setup_no_write", 32'(write_count), 32'(wc0));

        // Abort during the first WRITE cycle: full strobe and hold.
        wc0 = write_count;
        applyStimulus(1'b1, 1'b1, 8'h77);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_write_w1", 32'(wr_en), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_write_w2", 32'(wr_en), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_write_hold_wr", 32'(wr_en), 0);
        checkOutput("abort_write_hold_busy", 32'(busy), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("abort_write_idle_mux", 32'(mux_sel), 0);
        checkOutput("abort_write_done", 32'(done), 0);
        checkOutput("abort_write_addr", 32'(prog_addr), 1);
        checkOutput("abort_write_count", 32'(write_count), 32'(wc0 + 1));

        // Full fill with bytes 0x00..0x0F, each paced by data_ready.
        wc0 = write_count;
        applyStimulus(1'b1, 1'b0, 8'h00);
        b = 0;
        cycles = 0;
        while (b < DEPTH && cycles < 400) begin
            applyStimulus(1'b1, 1'b1, 8'(b));
            if (data_ready) b++;
            cycles++;
        end
        checkOutput("fill_accepted", 32'(b), 32'(DEPTH));
        cycles = 0;
        while (!done && cycles < 20) begin
            applyStimulus(1'b1, 1'b1, 8'hEE);
            cycles++;
        end
        checkOutput("fill_done", 32'(done), 1);
        checkOutput("fill_last_addr", 32'(prog_addr), 32'(DEPTH - 1));
        repeat (4) begin
            applyStimulus(1'b1, 1'b1, 8'hEE);
            checkOutput("fill_extra_ready", 32'(data_ready), 0);
        end
        checkOutput("fill_wr_data", 32'(wr_data), 32'h0F);
        checkOutput("fill_write_count", 32'(write_count), 32'(wc0 + DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("fill_mem", 32'(mem[i]), 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("fill_release_mux", 32'(mux_sel), 0);
        checkOutput("fill_release_done", 32'(done), 0);

        // Asynchronous reset in the middle of a WRITE cycle.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h5A);
        cycles = 0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        while (!wr_en && cycles < 10) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            cycles++;
        end
        checkOutput("areset_pre_wr_en", 32'(wr_en), 1);
        #2;
        rst_n   = 1'b0;
        prog_en = 1'b0;
        #1;
        checkOutput("areset_wr_en", 32'(wr_en), 0);
        checkOutput("areset_mux_sel", 32'(mux_sel), 0);
        checkOutput("areset_busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("areset_idle_mux", 32'(mux_sel), 0);
        checkOutput("areset_idle_ready", 32'(data_ready), 0);
        checkOutput("areset_idle_addr", 32'(prog_addr), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
